// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and ALU-side signal bundle for alu_arbiter
interface alu_arbiter_if #(
  parameter int WIDTH = 16
);
  // Port 0: main datapath requester
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_op;

  // Port 1: PC/branch-target requester
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_op;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_r;
  logic             rsp_zero;
  logic             rsp_ovfl;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_op;
  logic [WIDTH-1:0] alu_r;
  logic             alu_zero;
  logic             alu_ovfl;

  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    input  alu_r, alu_zero, alu_ovfl,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_r, rsp_zero, rsp_ovfl,
    output alu_a, alu_b, alu_op,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    output alu_r, alu_zero, alu_ovfl,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_r, rsp_zero, rsp_ovfl,
    input  alu_a, alu_b, alu_op,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sequencing one op at a time through the shared ALU
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic             prio;
  logic             gid;
  logic             grant;
  logic             is_idle;
  logic             accept0;
  logic             accept1;
  logic             rsp_done;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic             alu_op_q;
  logic [WIDTH-1:0] rsp_r_q;
  logic             rsp_zero_q;
  logic             rsp_ovfl_q;

  assign is_idle = (state == S_IDLE);

  // A lone valid wins outright; the pointer only breaks ties.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = prio;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign bus.req0_ready = is_idle && bus.req0_valid && !grant;
  assign bus.req1_ready = is_idle && bus.req1_valid &&  grant;

  assign accept0 = bus.req0_valid && bus.req0_ready;
  assign accept1 = bus.req1_valid && bus.req1_ready;

  // Only the owner of the in-flight op can retire it.
  assign rsp_done = gid ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      prio       <= 1'b0;
      gid        <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= 1'b0;
      rsp_r_q    <= '0;
      rsp_zero_q <= 1'b0;
      rsp_ovfl_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept0) begin
            alu_a_q  <= bus.req0_a;
            alu_b_q  <= bus.req0_b;
            alu_op_q <= bus.req0_op;
            gid      <= 1'b0;
            state    <= S_EXEC;
          end else if (accept1) begin
            alu_a_q  <= bus.req1_a;
            alu_b_q  <= bus.req1_b;
            alu_op_q <= bus.req1_op;
            gid      <= 1'b1;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_r_q    <= bus.alu_r;
          rsp_zero_q <= bus.alu_zero;
          rsp_ovfl_q <= bus.alu_ovfl;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_done) begin
            prio  <= ~gid;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_r      = rsp_r_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_ovfl   = rsp_ovfl_q;
  assign bus.rsp0_valid = (state == S_RESP) && !gid;
  assign bus.rsp1_valid = (state == S_RESP) &&  gid;
  assign bus.busy       = !is_idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter against a transaction-level model
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(16)) bus ();

  alu_arbiter #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural ALU sitting on the far side of the arbiter
  assign bus.alu_r    = bus.alu_op ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);
  assign bus.alu_zero = (bus.alu_r == 16'h0000);
  assign bus.alu_ovfl = bus.alu_op
                      ? ((bus.alu_a[15] != bus.alu_b[15]) && (bus.alu_r[15] != bus.alu_a[15]))
                      : ((bus.alu_a[15] == bus.alu_b[15]) && (bus.alu_r[15] != bus.alu_a[15]));

  int total = 0;
  int bad   = 0;
  bit prio_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected result from signed integer arithmetic rather than bit rules
  task automatic model_op(input logic [15:0] a, input logic [15:0] b, input bit op,
                          output logic [15:0] r, output bit z, output bit v);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = op ? (sa - sb) : (sa + sb);
    v  = (s > 32767) || (s < -32768);
    r  = s[15:0];
    z  = (r == 16'h0000);
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 1'b0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_rdy"},  {bus.req0_ready, bus.req1_ready}, 0);
    check({tag, "_rspv"}, {bus.rsp0_valid, bus.rsp1_valid}, 0);
    check({tag, "_alu"},  {bus.alu_a, bus.alu_b}, 0);
    check({tag, "_aluop"}, bus.alu_op, 0);
    check({tag, "_rsp"},  {bus.rsp_r, bus.rsp_zero, bus.rsp_ovfl}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n  = 1'b1;
    prio_m = 1'b0;
  endtask

  // One full transaction starting in an IDLE cycle; returns the granted port or -1
  task automatic round(input bit v0, input bit v1,
                       input logic [15:0] a0, input logic [15:0] b0, input bit op0,
                       input logic [15:0] a1, input logic [15:0] b1, input bit op1,
                       input int hold, input bit noise, output int g_out);
    int g;
    logic [15:0] ea, eb, er;
    bit eop, ez, ev;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
    #1;
    if (!v0 && !v1) begin
      check("none_rdy", {bus.req0_ready, bus.req1_ready}, 0);
      check("none_busy", bus.busy, 0);
      g_out = -1;
      return;
    end
    g = (v0 && v1) ? int'(prio_m) : (v0 ? 0 : 1);
    check("idle_rdy0", bus.req0_ready, (g == 0));
    check("idle_rdy1", bus.req1_ready, (g == 1));
    check("idle_busy", bus.busy, 0);
    ea  = (g == 0) ? a0 : a1;
    eb  = (g == 0) ? b0 : b1;
    eop = (g == 0) ? op0 : op1;
    model_op(ea, eb, eop, er, ez, ev);
    @(posedge clk);
    #1;
    if (g == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    @(negedge clk);
    check("exec_busy", bus.busy, 1);
    check("exec_rspv", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    check("exec_rdy", {bus.req0_ready, bus.req1_ready}, 0);
    check("exec_alu", {bus.alu_a, bus.alu_b, 15'd0, bus.alu_op}, {ea, eb, 15'd0, eop});
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      if (noise && i < hold) begin
        if (g == 0) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
      end
      #1;
      check("resp_v0", bus.rsp0_valid, (g == 0));
      check("resp_v1", bus.rsp1_valid, (g == 1));
      check("resp_r", bus.rsp_r, er);
      check("resp_flags", {bus.rsp_zero, bus.rsp_ovfl}, {ez, ev});
      check("resp_rdy", {bus.req0_ready, bus.req1_ready}, 0);
      check("resp_busy", bus.busy, 1);
      if (i == hold) begin
        if (g == 0) begin bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b0; end
        else        begin bus.rsp1_ready = 1'b1; bus.rsp0_ready = 1'b0; end
      end
    end
    @(posedge clk);
    #1;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    prio_m = (g == 0);
    g_out  = g;
  endtask

  initial begin
    int g;
    logic [15:0] ra0, rb0, ra1, rb1;
    bit rv0, rv1;
    logic [15:0] edge_vals [4];
    edge_vals[0] = 16'h7FFF; edge_vals[1] = 16'h8000;
    edge_vals[2] = 16'hFFFF; edge_vals[3] = 16'h0000;
    clear_inputs();
    rst_n  = 1'b0;
    prio_m = 1'b0;
    do_reset();

    round(1, 0, 16'h0005, 16'h0003, 0, 16'h0, 16'h0, 0, 0, 0, g);
    check("add_grant", g, 0);
    round(0, 1, 16'h0, 16'h0, 0, 16'h1234, 16'h1234, 1, 0, 0, g);
    check("sub_grant", g, 1);
    round(1, 0, 16'h7FFF, 16'h0001, 0, 16'h0, 16'h0, 0, 1, 0, g);
    check("ovfl_grant", g, 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      round(1, 1, 16'(i), 16'h0100, 0, 16'h0200, 16'(i), 1, 0, 0, g);
      check("rr_order", g, i % 2);
    end

    // Port 0 wins the tie, port 1 waits through 5 cycles of response backpressure
    round(1, 1, 16'h4444, 16'h1111, 1, 16'h0009, 16'h0001, 0, 5, 1, g);
    check("bp_grant0", g, 0);
    round(0, 1, 16'h0, 16'h0, 0, 16'h0009, 16'h0001, 0, 0, 0, g);
    check("bp_grant1", g, 1);

    // Leave the pointer favouring port 1, then abort an op in EXEC
    round(1, 0, 16'h0011, 16'h0022, 0, 16'h0, 16'h0, 0, 0, 0, g);
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_a = 16'h00AA; bus.req1_b = 16'h0001; bus.req1_op = 1'b0;
    @(posedge clk);
    #1 bus.req1_valid = 1'b0;
    @(negedge clk);
    check("abort_exec_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    rst_n  = 1'b1;
    prio_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.busy}, 0);
    end
    round(1, 1, 16'h0001, 16'h0001, 0, 16'h0002, 16'h0002, 0, 0, 0, g);
    check("post_rst_grant", g, 0);

    // Dropped valid: nothing pending means no ready and no accept
    round(0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0, g);
    check("none_grant", g, -1);

    for (int n = 0; n < 40; n++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      ra0 = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
      rb0 = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
      ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 16'($urandom);
      rb1 = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
      round(rv0, rv1, ra0, rb0, 1'($urandom_range(0, 1)), ra1, rb1, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), g);
      if (!rv0 && !rv1) check("rand_none", g, -1);
    end

    clear_inputs();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares the single 16-bit ALU between two requesters (port 0: main datapath, port 1: PC/branch-target unit). It accepts one operation at a time over a valid/ready handshake, drives registered operands and op to the ALU, captures the ALU result and flags, and returns them to the granted requester over a valid/ready response channel. It sits between the requesters and the ALU instance in the processor top level.

## Interface

- WIDTH, 16, operand/result width; must match the ALU.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_op / req1_op  in  1  ALU op: 0 = a+b, 1 = a−b.
- rsp0_valid / rsp1_valid  out  1  result available for that requester.
- rsp0_ready / rsp1_ready  in  1  requester takes the result.
- rsp_r  out  WIDTH  result (shared by both response ports).
- rsp_zero, rsp_ovfl  out  1  captured ALU zero / signed-overflow flags.
- alu_a, alu_b  out  WIDTH  registered operands to ALU.
- alu_op  out  1  registered op to ALU.
- alu_r  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_zero, alu_ovfl  in  1  ALU flags.
- busy  out  1  high in any state other than IDLE.

## Operation

- States: IDLE, EXEC, RESP. Reset state IDLE.
- Priority pointer prio (1 bit), reset 0 (port 0 favoured).
- IDLE grant: only one valid → that port; both valid → port prio; none → stay IDLE.
- reqN_ready = (state==IDLE) && grant==N; combinational, at most one high. Accept = valid && ready.
- On accept: latch reqN_a/b/op into alu_a/alu_b/alu_op, store grant id, go EXEC.
- EXEC (one cycle): ALU inputs stable; at end of cycle register alu_r/alu_zero/alu_ovfl into rsp_r/rsp_zero/rsp_ovfl; go RESP.
- RESP: rspN_valid high only for stored grant id; rsp_r/flags and alu_* held stable. On rspN_ready → go IDLE, prio ← ~grant id. Other port's rsp_ready ignored.
- No new request accepted outside IDLE regardless of valids.
- Requesters must hold valid and operands stable until ready; arbiter does not buffer unaccepted requests.
- Result is exactly the ALU output; no arithmetic in this block. Width mismatches not permitted (WIDTH fixed to ALU).

## Timing

- Reset values: all ready/valid/busy 0; alu_a, alu_b, rsp_r = 0; alu_op, rsp_zero, rsp_ovfl = 0; prio 0; state IDLE.
- Accept in cycle T → EXEC in T+1 → rspN_valid high from T+2.
- rsp_ready high in T+2 → IDLE in T+3; earliest next accept T+3 (3-cycle minimum per op).
- Response backpressure: RESP held indefinitely; outputs bit-stable.
- Simultaneous valids at IDLE with prio=1 → port 1 granted.
- Requester dropping valid in same cycle it would be granted: no accept; arbitration re-evaluated next cycle.
- Reset asserted in any state: immediate return to reset values; in-flight op discarded, no response issued.

## Test plan

- After reset, req0 add 0x0005+0x0003 accepted at T → rsp0_valid at T+2, rsp_r=0x0008, zero=0, ovfl=0; rsp1_valid stays 0.
- req1 sub 0x1234−0x1234 → rsp_r=0x0000, rsp_zero=1; req0 add 0x7FFF+0x0001 → rsp_r=0x8000, rsp_ovfl=1.
- Both valid continuously from reset, four ops → grant order 0,1,0,1; ready never high on both ports.
- rsp0_ready held low 5 cycles in RESP with req1_valid high → rsp_r/flags stable, req1_ready stays 0; after rsp0_ready, req1 accepted next IDLE cycle.
- rst_n pulsed low during EXEC → all outputs return to reset values asynchronously, no rsp_valid follows; next op after reset grants port 0 if both valid.
- rsp1_ready high while port 0 in RESP → ignored, state stays RESP.
